// File: rtl/mu0_mem_pkg.sv
// rtl/mu0_mem_pkg.sv - shared types, MMIO offsets and address decode for the MU0 memory responder
package mu0_mem_pkg;

  localparam int WORD_W = 16;
  typedef logic [WORD_W-1:0] word_t;

  // Word offsets inside the 16-word MMIO page
  localparam logic [3:0] OFF_CON_DATA = 4'd0;
  localparam logic [3:0] OFF_CON_STAT = 4'd1;
  localparam logic [3:0] OFF_CYC_LO   = 4'd2;
  localparam logic [3:0] OFF_CYC_HI   = 4'd3;
  localparam logic [3:0] OFF_SCRATCH  = 4'd4;

  // CON_STAT bit positions
  localparam int STAT_EMPTY = 0;
  localparam int STAT_FULL  = 1;
  localparam int STAT_OVF   = 2;

  typedef enum logic [1:0] {
    REG_NONE = 2'd0,
    REG_RAM  = 2'd1,
    REG_MMIO = 2'd2
  } region_e;

  // Only the low 4K word window is populated; RAM sits at the bottom, MMIO page at the top
  function automatic region_e decode_region(input word_t a, input word_t ram_words,
                                            input word_t mmio_base);
    region_e r;
    r = REG_NONE;
    if (a[15:12] == 4'h0) begin
      if (a < ram_words) begin
        r = REG_RAM;
      end else if (a >= mmio_base) begin
        r = REG_MMIO;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with simultaneous push/pop, head word exposed directly
module sync_fifo #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [DATA_W-1:0]        head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q;
  logic [AW-1:0]     rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              do_push;
  logic              do_pop;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;
  // A pop frees a slot in the same cycle, so a push into a full FIFO is accepted alongside it
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  // Head is driven to zero while empty so the consumer never sees stale words
  assign head_data = empty ? '0 : mem_q[rd_ptr_q];

  // Storage: written on accepted pushes only; contents need no reset
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_data;
    end
  end

  // Pointers and occupancy; power-of-two depth lets the pointers wrap naturally
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr_q <= wr_ptr_q + AW'(1);
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/mu0_mem_responder.sv
// rtl/mu0_mem_responder.sv - MU0 memory bus responder: word RAM, console FIFO, cycle counter, scratch
module mu0_mem_responder
  import mu0_mem_pkg::*;
#(
  parameter int          RAM_WORDS  = 4080,
  parameter logic [15:0] MMIO_BASE  = 16'h0FF0,
  parameter int          FIFO_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRq,
  input  logic        readNotWrite,
  input  logic [15:0] addr,
  input  logic [15:0] dataIn,
  output logic [15:0] dataOut,
  output logic [15:0] conData,
  output logic        conValid,
  input  logic        conReady,
  output logic        busErr
);

  localparam int RAM_AW = $clog2(RAM_WORDS);
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  word_t             ram_q [RAM_WORDS];
  word_t             ram_rd_q;
  word_t             mmio_rd_q;
  word_t             mmio_rd_d;
  logic              sel_ram_q;
  logic [31:0]       cyc_cnt_q;
  word_t             shadow_q;
  word_t             scratch_q;
  logic              overflow_q;
  logic              overflow_d;
  logic              bus_err_q;

  region_e           region;
  logic [3:0]        off;
  logic [RAM_AW-1:0] ram_idx;
  logic              rd_en;
  logic              wr_en;
  logic              mmio_wr;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  word_t             fifo_head;

  assign region  = decode_region(addr, 16'(RAM_WORDS), MMIO_BASE);
  // The MMIO page is 16-word aligned, so the low address nibble is the register offset
  assign off     = addr[3:0];
  assign ram_idx = addr[RAM_AW-1:0];
  assign rd_en   = memRq & readNotWrite;
  assign wr_en   = memRq & ~readNotWrite;
  assign mmio_wr = wr_en && (region == REG_MMIO);

  assign fifo_pop  = ~fifo_empty & conReady;
  assign fifo_push = mmio_wr && (off == OFF_CON_DATA);

  sync_fifo #(
    .DATA_W (WORD_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_con_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (dataIn),
    .pop       (fifo_pop),
    .head_data (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign conData  = fifo_head;
  assign conValid = ~fifo_empty;
  assign busErr   = bus_err_q;
  // Read data lives in either the RAM output register or the MMIO read register
  assign dataOut  = sel_ram_q ? ram_rd_q : mmio_rd_q;

  // MMIO read mux and overflow flag next state; a push-side overflow beats a same-cycle clear
  always_comb begin
    mmio_rd_d  = '0;
    overflow_d = overflow_q;
    if (region == REG_MMIO) begin
      case (off)
        OFF_CON_STAT: begin
          mmio_rd_d[STAT_EMPTY] = (fifo_count == '0);
          mmio_rd_d[STAT_FULL]  = (fifo_count == CNT_W'(FIFO_DEPTH));
          mmio_rd_d[STAT_OVF]   = overflow_q;
        end
        OFF_CYC_LO:  mmio_rd_d = cyc_cnt_q[15:0];
        OFF_CYC_HI:  mmio_rd_d = shadow_q;
        OFF_SCRATCH: mmio_rd_d = scratch_q;
        default:     mmio_rd_d = '0;
      endcase
    end
    if (mmio_wr && (off == OFF_CON_STAT) && dataIn[0]) begin
      overflow_d = 1'b0;
    end
    if (fifo_push && fifo_full && !fifo_pop) begin
      overflow_d = 1'b1;
    end
  end

  // RAM port: writes commit at the request edge, reads land in the RAM output register
  always_ff @(posedge clk) begin
    if (!rst && memRq && (region == REG_RAM)) begin
      if (readNotWrite) begin
        ram_rd_q <= ram_q[ram_idx];
      end else begin
        ram_q[ram_idx] <= dataIn;
      end
    end
  end

  // MMIO registers, cycle counter, read-path select and sticky bus error
  always_ff @(posedge clk) begin
    if (rst) begin
      mmio_rd_q  <= '0;
      sel_ram_q  <= 1'b0;
      cyc_cnt_q  <= '0;
      shadow_q   <= '0;
      scratch_q  <= '0;
      overflow_q <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      cyc_cnt_q  <= cyc_cnt_q + 32'd1;
      overflow_q <= overflow_d;
      if (memRq && (region == REG_NONE)) begin
        bus_err_q <= 1'b1;
      end
      if (rd_en) begin
        sel_ram_q <= (region == REG_RAM);
        mmio_rd_q <= mmio_rd_d;
        // Latch the upper half with the lower-half read so CYC_HI pairs with it
        if ((region == REG_MMIO) && (off == OFF_CYC_LO)) begin
          shadow_q <= cyc_cnt_q[31:16];
        end
      end
      if (mmio_wr && (off == OFF_SCRATCH)) begin
        scratch_q <= dataIn;
      end
    end
  end

endmodule

// File: tb/tb_mu0_mem_responder.sv
// tb/tb_mu0_mem_responder.sv - self-checking bench for mu0_mem_responder
module tb_mu0_mem_responder;

  localparam int FDEPTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        memRq = 1'b0;
  logic        readNotWrite = 1'b1;
  logic [15:0] addr = 16'h0;
  logic [15:0] dataIn = 16'h0;
  logic [15:0] dataOut;
  logic [15:0] conData;
  logic        conValid;
  logic        conReady = 1'b0;
  logic        busErr;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [15:0] ram_m [int];
  logic [15:0] fifo_m [$];
  logic [31:0] cnt_m = 32'h0;
  logic [15:0] dout_m = 16'h0;
  logic [15:0] scratch_m = 16'h0;
  logic [15:0] shadow_m = 16'h0;
  logic        ovf_m = 1'b0;
  logic        berr_m = 1'b0;

  typedef struct {
    logic        rnw;
    logic [15:0] a;
    logic [15:0] d;
    logic [15:0] exp_dout;
    logic        exp_berr;
  } vec_t;

  vec_t tbl [11];

  mu0_mem_responder dut (
    .clk          (clk),
    .rst          (rst),
    .memRq        (memRq),
    .readNotWrite (readNotWrite),
    .addr         (addr),
    .dataIn       (dataIn),
    .dataOut      (dataOut),
    .conData      (conData),
    .conValid     (conValid),
    .conReady     (conReady),
    .busErr       (busErr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // One bus cycle of the reference model, taken from the map description
  task automatic model_step(input logic rq, input logic rnw, input logic [15:0] a,
                            input logic [15:0] d, input logic rdy);
    bit is_ram;
    bit is_mmio;
    bit pop;
    int off;
    is_ram  = (a < 16'd4080);
    is_mmio = (a >= 16'h0FF0) && (a <= 16'h0FFF);
    off     = int'(a) - 'h0FF0;
    pop     = rdy && (fifo_m.size() != 0);
    if (rq && rnw) begin
      if (is_ram) begin
        dout_m = ram_m[int'(a)];
      end else if (is_mmio) begin
        case (off)
          1: dout_m = {13'd0, ovf_m, fifo_m.size() == FDEPTH, fifo_m.size() == 0};
          2: begin dout_m = cnt_m[15:0]; shadow_m = cnt_m[31:16]; end
          3: dout_m = shadow_m;
          4: dout_m = scratch_m;
          default: dout_m = 16'h0;
        endcase
      end else begin
        dout_m = 16'h0;
        berr_m = 1'b1;
      end
    end
    if (pop) void'(fifo_m.pop_front());
    if (rq && !rnw) begin
      if (is_ram) begin
        ram_m[int'(a)] = d;
      end else if (is_mmio) begin
        if (off == 0) begin
          if (fifo_m.size() < FDEPTH) fifo_m.push_back(d);
          else ovf_m = 1'b1;
        end else if (off == 1 && d[0]) begin
          ovf_m = 1'b0;
        end else if (off == 4) begin
          scratch_m = d;
        end
      end else begin
        berr_m = 1'b1;
      end
    end
    cnt_m = cnt_m + 32'd1;
  endtask

  task automatic do_cycle(input logic rq, input logic rnw, input logic [15:0] a,
                          input logic [15:0] d, input logic rdy);
    memRq = rq; readNotWrite = rnw; addr = a; dataIn = d; conReady = rdy;
    model_step(rq, rnw, a, d, rdy);
    @(posedge clk); #1;
    check("dataOut", dataOut, dout_m);
    check("busErr", busErr, berr_m);
    check("conValid", conValid, fifo_m.size() != 0);
    check("conData", conData, (fifo_m.size() != 0) ? fifo_m[0] : 16'h0);
    memRq = 1'b0;
  endtask

  task automatic do_reset(input logic rq, input logic rnw, input logic [15:0] a,
                          input logic [15:0] d);
    rst = 1'b1; memRq = rq; readNotWrite = rnw; addr = a; dataIn = d; conReady = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0; memRq = 1'b0;
    fifo_m.delete();
    ovf_m = 1'b0; cnt_m = 32'h0; scratch_m = 16'h0; shadow_m = 16'h0;
    berr_m = 1'b0; dout_m = 16'h0;
  endtask

  initial begin
    logic [15:0] ram_pick [6];
    ram_pick = '{16'h0000, 16'h0005, 16'h0123, 16'h0800, 16'h0FEE, 16'h0FEF};

    tbl[0]  = '{1'b0, 16'h0005, 16'h1234, 16'h0000, 1'b0};
    tbl[1]  = '{1'b1, 16'h0005, 16'h0000, 16'h1234, 1'b0};
    tbl[2]  = '{1'b0, 16'h0FEF, 16'h5A5A, 16'h1234, 1'b0};
    tbl[3]  = '{1'b1, 16'h0FEF, 16'h0000, 16'h5A5A, 1'b0};
    tbl[4]  = '{1'b0, 16'h0FF4, 16'hBEEF, 16'h5A5A, 1'b0};
    tbl[5]  = '{1'b1, 16'h0FF4, 16'h0000, 16'hBEEF, 1'b0};
    tbl[6]  = '{1'b0, 16'h0FF9, 16'h1111, 16'hBEEF, 1'b0};
    tbl[7]  = '{1'b1, 16'h0FF9, 16'h0000, 16'h0000, 1'b0};
    tbl[8]  = '{1'b1, 16'h0FF1, 16'h0000, 16'h0001, 1'b0};
    tbl[9]  = '{1'b1, 16'h0FF0, 16'h0000, 16'h0000, 1'b0};
    tbl[10] = '{1'b1, 16'h0005, 16'h0000, 16'h1234, 1'b0};

    do_reset(1'b0, 1'b1, 16'h0, 16'h0);
    check("rst_dataOut", dataOut, 16'h0);
    check("rst_conValid", conValid, 1'b0);
    check("rst_conData", conData, 16'h0);
    check("rst_busErr", busErr, 1'b0);

    // Decode and basic read/write vectors
    for (int i = 0; i < 11; i++) begin
      do_cycle(1'b1, tbl[i].rnw, tbl[i].a, tbl[i].d, 1'b0);
      check($sformatf("tbl%0d_dout", i), dataOut, tbl[i].exp_dout);
      check($sformatf("tbl%0d_berr", i), busErr, tbl[i].exp_berr);
    end

    // Push into empty FIFO with sink ready: visible next cycle, popped on it
    do_cycle(1'b1, 1'b0, 16'h0FF0, 16'hABCD, 1'b1);
    check("t6_valid", conValid, 1'b1);
    check("t6_data", conData, 16'hABCD);
    do_cycle(1'b0, 1'b1, 16'h0, 16'h0, 1'b1);
    check("t6_drained", conValid, 1'b0);
    do_cycle(1'b1, 1'b1, 16'h0FF1, 16'h0, 1'b0);
    check("t6_stat", dataOut, 16'h0001);

    // Overflow on the ninth push, then clear
    for (int i = 0; i < 9; i++) do_cycle(1'b1, 1'b0, 16'h0FF0, 16'h0100 + 16'(i), 1'b0);
    do_cycle(1'b1, 1'b1, 16'h0FF1, 16'h0, 1'b0);
    check("t2_stat_ovf", dataOut, 16'h0006);
    do_cycle(1'b1, 1'b0, 16'h0FF1, 16'h0001, 1'b0);
    do_cycle(1'b1, 1'b1, 16'h0FF1, 16'h0, 1'b0);
    check("t2_stat_clr", dataOut, 16'h0002);

    // Full FIFO: push and pop together keep it full without overflow
    do_cycle(1'b1, 1'b0, 16'h0FF0, 16'h0200, 1'b1);
    do_cycle(1'b1, 1'b1, 16'h0FF1, 16'h0, 1'b0);
    check("t3_stat", dataOut, 16'h0002);
    for (int k = 0; k < 8; k++) begin
      check($sformatf("t3_order%0d", k), conData, (k < 7) ? 16'h0101 + 16'(k) : 16'h0200);
      do_cycle(1'b0, 1'b1, 16'h0, 16'h0, 1'b1);
    end
    check("t3_empty", conValid, 1'b0);

    // Unmapped read, sticky error, reset mid-stream
    do_cycle(1'b1, 1'b1, 16'h1000, 16'h0, 1'b0);
    check("t5_unmapped_dout", dataOut, 16'h0);
    check("t5_unmapped_berr", busErr, 1'b1);
    do_cycle(1'b1, 1'b1, 16'h0005, 16'h0, 1'b0);
    check("t5_sticky", busErr, 1'b1);
    for (int i = 0; i < 3; i++) do_cycle(1'b1, 1'b0, 16'h0FF0, 16'h0301 + 16'(i), 1'b0);
    check("t5_fifo_holds", conValid, 1'b1);
    do_reset(1'b1, 1'b0, 16'h0005, 16'hDEAD);
    check("t5_rst_valid", conValid, 1'b0);
    check("t5_rst_berr", busErr, 1'b0);
    check("t5_rst_dout", dataOut, 16'h0);
    do_cycle(1'b1, 1'b1, 16'h0005, 16'h0, 1'b0);
    check("t5_ram_kept", dataOut, 16'h1234);

    // Coherent counter pair across the 16-bit carry
    do_reset(1'b0, 1'b1, 16'h0, 16'h0);
    while (cnt_m != 32'h0000_FFFF) do_cycle(1'b0, 1'b1, 16'h0, 16'h0, 1'b0);
    do_cycle(1'b1, 1'b1, 16'h0FF2, 16'h0, 1'b0);
    check("t4_cyc_lo", dataOut, 16'hFFFF);
    do_cycle(1'b0, 1'b1, 16'h0, 16'h0, 1'b0);
    do_cycle(1'b1, 1'b1, 16'h0FF3, 16'h0, 1'b0);
    check("t4_cyc_hi", dataOut, 16'h0000);
    do_cycle(1'b1, 1'b1, 16'h0FF2, 16'h0, 1'b0);
    check("t4_cyc_lo_live", dataOut, 16'h0002);

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic        rq;
      logic        rnw;
      logic        rdy;
      logic [15:0] a;
      logic [15:0] d;
      int          kind;
      kind = $urandom_range(0, 99);
      if (kind < 45)      a = ram_pick[$urandom_range(0, 5)];
      else if (kind < 97) a = 16'h0FF0 + 16'($urandom_range(0, 15));
      else                a = {4'($urandom_range(1, 15)), 12'($urandom)};
      rnw = 1'($urandom_range(0, 1));
      if (rnw && (a < 16'd4080) && !ram_m.exists(int'(a))) rnw = 1'b0;
      d   = 16'($urandom);
      rq  = ($urandom_range(0, 3) != 0);
      rdy = 1'($urandom_range(0, 1));
      do_cycle(rq, rnw, a, d, rdy);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
